// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder/subtractor):
// state encodings, state width and default decoy encodings.
package serial_arith_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_SUB  = 3'd1,
    ST_DONE = 3'd2
  } state_t;

  localparam logic [STATE_W-1:0] DEF_DECOY0 = 3'd3;
  localparam logic [STATE_W-1:0] DEF_DECOY1 = 3'd4;

endpackage

// File: rtl/bit_sub_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module bit_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: loads masked operands, subtracts LSB-first one bit per
// clock and shifts the difference into out; decoy state encodings are defined but unreachable.
module sub_serial
  import serial_arith_pkg::*;
#(
  parameter int                 WIDTH  = 8,
  parameter logic [WIDTH-1:0]   A_MASK = '0,
  parameter logic [WIDTH-1:0]   B_MASK = '0,
  parameter logic [STATE_W-1:0] DECOY0 = DEF_DECOY0,
  parameter logic [STATE_W-1:0] DECOY1 = DEF_DECOY1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               borrow;
  logic [CNT_W-1:0]   count;
  logic               d_bit;
  logic               bout_bit;

  logic in_sub;
  logic in_d0;
  logic in_d1;
  logic load;
  logic last;

  assign in_sub = (state == ST_SUB);
  assign in_d0  = (state == DECOY0);
  assign in_d1  = (state == DECOY1);
  assign load   = en && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = in_sub && (count == LAST);

  bit_sub_cell u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Unknown encodings fall back to IDLE so a corrupted state self-recovers.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: next_state = en ? ST_SUB : ST_IDLE;
      ST_SUB:  next_state = (count == LAST) ? ST_DONE : ST_SUB;
      ST_DONE: next_state = en ? ST_SUB : ST_DONE;
      DECOY0:  next_state = ST_IDLE;
      DECOY1:  next_state = en ? ST_DONE : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SUB);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         a_reg <= '0;
    else if (load)   a_reg <= a ^ A_MASK;
    else if (in_sub) a_reg <= a_reg >> 1;
    else if (in_d0)  a_reg <= a_reg << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  b_reg <= '0;
    else if (load)            b_reg <= b ^ B_MASK;
    else if (in_sub || in_d0) b_reg <= b_reg >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 borrow <= 1'b0;
    else if (load || in_d1)  borrow <= 1'b0;
    else if (in_sub)         borrow <= bout_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (load || in_d1) count <= '0;
    else if (in_sub)        count <= count + 1'b1;
  end

  // Difference bits enter at the MSB so the first (LSB) bit lands at out[0] after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out <= '0;
    else if (load)   out <= '0;
    else if (in_sub) out <= {d_bit, out[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       borrow_out <= 1'b0;
    else if (last) borrow_out <= bout_bit;
  end

endmodule
